// File: rtl/strength_adder.sv
// Three independent saturating RGB strength accumulators. Each enabled channel
// adds the same unsigned sample per clock; outputs come straight from registers.
module strength_adder #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 22
) (
  input  logic [IN_W-1:0]  strength_input,
  input  logic             Radd_en,
  input  logic             Gadd_en,
  input  logic             Badd_en,
  input  logic             clk,
  input  logic             reset,
  output logic [ACC_W-1:0] Rstrength,
  output logic [ACC_W-1:0] Gstrength,
  output logic [ACC_W-1:0] Bstrength
);

  // One guard bit catches the carry out; any carry means the true sum is
  // beyond the accumulator range, so the result pins at all-ones.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [IN_W-1:0]  smp);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W+1-IN_W){1'b0}}, smp};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] r_acc_q, r_acc_d;
  logic [ACC_W-1:0] g_acc_q, g_acc_d;
  logic [ACC_W-1:0] b_acc_q, b_acc_d;

  always_comb begin
    r_acc_d = r_acc_q;
    g_acc_d = g_acc_q;
    b_acc_d = b_acc_q;
    if (Radd_en) r_acc_d = sat_add(r_acc_q, strength_input);
    if (Gadd_en) g_acc_d = sat_add(g_acc_q, strength_input);
    if (Badd_en) b_acc_d = sat_add(b_acc_q, strength_input);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_q <= '0;
      g_acc_q <= '0;
      b_acc_q <= '0;
    end else begin
      r_acc_q <= r_acc_d;
      g_acc_q <= g_acc_d;
      b_acc_q <= b_acc_d;
    end
  end

  assign Rstrength = r_acc_q;
  assign Gstrength = g_acc_q;
  assign Bstrength = b_acc_q;

endmodule

// File: tb/tb_strength_adder.sv
// Directed bench for strength_adder: a default 22-bit instance plus a 10-bit
// instance sharing the same inputs, so saturation shows up quickly.
module tb_strength_adder;

  localparam int IN_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [IN_W-1:0] strength_input;
  logic            Radd_en, Gadd_en, Badd_en;
  logic [21:0]     Rstrength, Gstrength, Bstrength;
  logic [9:0]      Rs_small, Gs_small, Bs_small;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  strength_adder #(.IN_W(IN_W), .ACC_W(22)) dut (
    .strength_input(strength_input), .Radd_en(Radd_en), .Gadd_en(Gadd_en),
    .Badd_en(Badd_en), .clk(clk), .reset(reset),
    .Rstrength(Rstrength), .Gstrength(Gstrength), .Bstrength(Bstrength)
  );

  strength_adder #(.IN_W(IN_W), .ACC_W(10)) dut_small (
    .strength_input(strength_input), .Radd_en(Radd_en), .Gadd_en(Gadd_en),
    .Badd_en(Badd_en), .clk(clk), .reset(reset),
    .Rstrength(Rs_small), .Gstrength(Gs_small), .Bstrength(Bs_small)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [31:0] r, input logic [31:0] g,
                         input logic [31:0] b);
    chk({tag, ".R"}, 32'(Rstrength), r);
    chk({tag, ".G"}, 32'(Gstrength), g);
    chk({tag, ".B"}, 32'(Bstrength), b);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_en(input logic r, input logic g, input logic b, input logic [IN_W-1:0] s);
    Radd_en = r; Gadd_en = g; Badd_en = b; strength_input = s;
  endtask

  initial begin
    set_en(0, 0, 0, 8'd0);
    reset = 1'b0;
    #1;
    chk_rgb("reset0", 0, 0, 0);
    step(2);
    reset = 1'b1;

    // Enables low: nothing accumulates
    set_en(0, 0, 0, 8'd100);
    step(2);
    chk_rgb("idle", 0, 0, 0);

    // R ramp, one step per cycle
    set_en(1, 0, 0, 8'd100);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk($sformatf("ramp%0d", k), 32'(Rstrength), 32'(100 * k));
    end
    chk("ramp.G", 32'(Gstrength), 0);
    chk("ramp.B", 32'(Bstrength), 0);

    set_en(0, 1, 0, 8'd100); step(1);
    set_en(0, 0, 1, 8'd100); step(2);
    set_en(1, 0, 0, 8'd100); step(8);
    set_en(0, 1, 0, 8'd100); step(1);
    set_en(0, 0, 1, 8'd100); step(2);
    set_en(1, 0, 0, 8'd100); step(2);
    chk_rgb("seq", 1500, 200, 400);
    chk("seq.small_sat", 32'(Rs_small), 1023);
    chk("seq.small_G", 32'(Gs_small), 200);

    // Hold with no enables regardless of sample value
    set_en(0, 0, 0, 8'd77);
    step(3);
    chk_rgb("hold", 1500, 200, 400);

    // Enable glitch between edges must be ignored
    #2 Radd_en = 1'b1;
    #2 Radd_en = 1'b0;
    step(1);
    chk("glitch.R", 32'(Rstrength), 1500);

    // Zero sample with enable high
    set_en(1, 1, 1, 8'd0);
    step(1);
    chk_rgb("addzero", 1500, 200, 400);

    // Async reset mid-accumulation
    set_en(1, 0, 0, 8'd100);
    step(1);
    chk("pre_rst.R", 32'(Rstrength), 1600);
    #2 reset = 1'b0;
    #1;
    chk_rgb("async_rst", 0, 0, 0);
    set_en(1, 1, 1, 8'd200);
    step(2);
    chk_rgb("rst_held", 0, 0, 0);
    reset = 1'b1;
    set_en(1, 0, 0, 8'd100);
    step(1);
    chk_rgb("post_rst", 100, 0, 0);

    // All channels together from reset
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    set_en(1, 1, 1, 8'd255);
    step(3);
    chk_rgb("all3", 765, 765, 765);
    chk("all3.small", 32'(Bs_small), 765);
    step(1);
    chk("small.1020", 32'(Rs_small), 1020);
    step(1);
    chk("small.sat", 32'(Rs_small), 1023);
    chk("big.nosat", 32'(Rstrength), 1275);
    step(1);
    chk("small.stay", 32'(Gs_small), 1023);

    // Drive the 22-bit instance into saturation: 16449 adds of 255 exceed 2^22-1
    step(16460 - 6);
    chk_rgb("big.sat", 4194303, 4194303, 4194303);
    step(2);
    chk("big.stay", 32'(Rstrength), 4194303);

    set_en(0, 0, 0, 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
